// File: rtl/gpio_seq_pkg.sv
// Shared definitions for the GPIO pattern sequencer: register map, CTRL bits, states, payloads.
package gpio_seq_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned STEP_W = 4;
  localparam int unsigned DLY_W  = 8;
  localparam int unsigned VAL_W  = 16;

  // Sequencer register offsets
  localparam logic [ADDR_W-1:0] SEQ_CTRL  = 3'd0;
  localparam logic [ADDR_W-1:0] SEQ_LEN   = 3'd1;
  localparam logic [ADDR_W-1:0] SEQ_INDEX = 3'd2;
  localparam logic [ADDR_W-1:0] SEQ_HI    = 3'd3;
  localparam logic [ADDR_W-1:0] SEQ_LO    = 3'd4;
  localparam logic [ADDR_W-1:0] SEQ_DLY   = 3'd5;
  localparam logic [ADDR_W-1:0] SEQ_PRESC = 3'd6;
  localparam logic [ADDR_W-1:0] SEQ_STEP  = 3'd7;

  // CTRL write bits
  localparam int unsigned CTRL_START = 0;
  localparam int unsigned CTRL_LOOP  = 1;
  localparam int unsigned CTRL_STOP  = 2;

  // GPIO slave addresses driven by the sequencer
  localparam logic [1:0] GPIO_HI = 2'b00;
  localparam logic [1:0] GPIO_LO = 2'b01;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WR_HI = 2'd1,
    S_WR_LO = 2'd2,
    S_WAIT  = 2'd3
  } state_t;

  // One pattern table step
  typedef struct packed {
    logic [VAL_W-1:0] val;
    logic [DLY_W-1:0] dly;
  } entry_t;

  // GPIO slave-port bus
  typedef struct packed {
    logic              cs;
    logic              rw;
    logic [1:0]        ad;
    logic [DATA_W-1:0] di;
  } gbus_t;

endpackage

// File: rtl/gpio_seq_timer.sv
// Inter-step delay timer: prescaler divides the clock by presc+1, down counter counts dly ticks.
module gpio_seq_timer
  import gpio_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             clr,
  input  logic             run,
  input  logic [DLY_W-1:0] dly,
  input  logic [DLY_W-1:0] presc,
  output logic             expired
);

  logic [DLY_W-1:0] cnt;
  logic [DLY_W-1:0] pre;

  // Prescaler and tick counter; loaded on WR_LO exit, decremented while running
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      pre <= '0;
    end else if (clr) begin
      cnt <= '0;
      pre <= '0;
    end else if (load) begin
      cnt <= dly;
      pre <= presc;
    end else if (run && (cnt != '0)) begin
      if (pre == '0) begin
        pre <= presc;
        cnt <= cnt - DLY_W'(1);
      end else begin
        pre <= pre - DLY_W'(1);
      end
    end
  end

  // Flags the last clock of a dly*(presc+1) wait so the FSM leaves exactly on time
  assign expired = run && (cnt == DLY_W'(1)) && (pre == '0);

endmodule

// File: rtl/gpio_seq.sv
// GPIO pattern sequencer and CPU/sequencer arbiter in front of the GPIO slave port.
module gpio_seq
  import gpio_seq_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] AD,
  input  logic [DATA_W-1:0] DI,
  output logic [DATA_W-1:0] DO,
  input  logic              rw,
  input  logic              cs,
  input  logic [1:0]        c_AD,
  input  logic [DATA_W-1:0] c_DI,
  input  logic              c_rw,
  input  logic              c_cs,
  output logic [1:0]        g_AD,
  output logic [DATA_W-1:0] g_DI,
  output logic              g_rw,
  output logic              g_cs,
  output logic              busy
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LEN_W = $clog2(DEPTH + 1);
  localparam int unsigned CMP_W = STEP_W + 2;

  state_t             state, state_nxt;
  logic [STEP_W-1:0]  step, step_nxt;
  logic [LEN_W-1:0]   len;
  logic [IDX_W-1:0]   idx;
  logic [DLY_W-1:0]   presc;
  logic               loop;
  logic               done;
  logic               done_set;
  logic               adv;
  logic               tmr_load, tmr_clr, tmr_expired;
  logic               reg_wr, ctrl_wr, ctrl_rd, last_step;
  entry_t             tbl [DEPTH];
  entry_t             cur;
  gbus_t              gbus;

  assign reg_wr    = cs && !rw;
  assign ctrl_wr   = reg_wr && (AD == SEQ_CTRL);
  assign ctrl_rd   = cs && rw && (AD == SEQ_CTRL);
  assign cur       = tbl[step[IDX_W-1:0]];
  assign last_step = (CMP_W'(step) + CMP_W'(1)) >= CMP_W'(len);
  assign busy      = (state != S_IDLE);

  gpio_seq_timer u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (tmr_load),
    .clr     (tmr_clr),
    .run     (state == S_WAIT),
    .dly     (cur.dly),
    .presc   (presc),
    .expired (tmr_expired)
  );

  // State and step register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      step  <= '0;
    end else begin
      state <= state_nxt;
      step  <= step_nxt;
    end
  end

  // Next state: STOP beats START, START beats normal sequencing; WR states stall on CPU traffic
  always_comb begin
    state_nxt = state;
    step_nxt  = step;
    done_set  = 1'b0;
    tmr_load  = 1'b0;
    tmr_clr   = 1'b0;
    adv       = 1'b0;
    if (ctrl_wr && DI[CTRL_STOP]) begin
      state_nxt = S_IDLE;
    end else if (ctrl_wr && DI[CTRL_START]) begin
      if (len == '0) begin
        state_nxt = S_IDLE;
        done_set  = 1'b1;
      end else begin
        state_nxt = S_WR_HI;
        step_nxt  = '0;
        tmr_clr   = 1'b1;
      end
    end else begin
      unique case (state)
        S_WR_HI: if (!c_cs) state_nxt = S_WR_LO;
        S_WR_LO: begin
          if (!c_cs) begin
            if (cur.dly == '0) begin
              adv = 1'b1;
            end else begin
              tmr_load  = 1'b1;
              state_nxt = S_WAIT;
            end
          end
        end
        S_WAIT:  if (tmr_expired) adv = 1'b1;
        default: ;
      endcase
      if (adv) begin
        if (!last_step) begin
          step_nxt  = step + STEP_W'(1);
          state_nxt = S_WR_HI;
        end else if (loop) begin
          step_nxt  = '0;
          state_nxt = S_WR_HI;
        end else begin
          state_nxt = S_IDLE;
          done_set  = 1'b1;
        end
      end
    end
  end

  // Control/status registers written from the CPU register port
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len   <= '0;
      idx   <= '0;
      presc <= '0;
      loop  <= 1'b0;
      done  <= 1'b0;
    end else begin
      if (done_set)     done <= 1'b1;
      else if (ctrl_rd) done <= 1'b0;
      if (reg_wr) begin
        unique case (AD)
          SEQ_CTRL:  loop  <= DI[CTRL_LOOP];
          SEQ_LEN:   len   <= (DI > DATA_W'(DEPTH)) ? LEN_W'(DEPTH) : LEN_W'(DI);
          SEQ_INDEX: idx   <= DI[IDX_W-1:0];
          SEQ_DLY:   idx   <= idx + IDX_W'(1);
          SEQ_PRESC: presc <= DI;
          default:   ;
        endcase
      end
    end
  end

  // Pattern table storage; contents are not reset
  always_ff @(posedge clk) begin
    if (reg_wr) begin
      unique case (AD)
        SEQ_HI:  tbl[idx].val[15:8] <= DI;
        SEQ_LO:  tbl[idx].val[7:0]  <= DI;
        SEQ_DLY: tbl[idx].dly       <= DI;
        default: ;
      endcase
    end
  end

  // Register read mux
  always_comb begin
    DO = '0;
    unique case (AD)
      SEQ_CTRL:  DO = {4'b0, done, 1'b0, loop, busy};
      SEQ_LEN:   DO = DATA_W'(len);
      SEQ_INDEX: DO = DATA_W'(idx);
      SEQ_HI:    DO = tbl[idx].val[15:8];
      SEQ_LO:    DO = tbl[idx].val[7:0];
      SEQ_DLY:   DO = tbl[idx].dly;
      SEQ_PRESC: DO = presc;
      SEQ_STEP:  DO = DATA_W'(step);
      default:   DO = '0;
    endcase
  end

  // GPIO port arbitration: CPU always wins, sequencer drives only in its write states
  always_comb begin
    gbus = '0;
    if (c_cs) begin
      gbus = '{cs: 1'b1, rw: c_rw, ad: c_AD, di: c_DI};
    end else if (state == S_WR_HI) begin
      gbus = '{cs: 1'b1, rw: 1'b0, ad: GPIO_HI, di: cur.val[15:8]};
    end else if (state == S_WR_LO) begin
      gbus = '{cs: 1'b1, rw: 1'b0, ad: GPIO_LO, di: cur.val[7:0]};
    end
  end

  assign g_cs = gbus.cs;
  assign g_rw = gbus.rw;
  assign g_AD = gbus.ad;
  assign g_DI = gbus.di;

endmodule
